// File: rtl/fetch_queue.sv
// Circular {instruction, PC} queue between instruction fetch and decode.
// Optional zero-latency empty-queue bypass is enabled with FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int unsigned   DEPTH    = 4,
  parameter int unsigned   IW       = 32,
  parameter int unsigned   AW       = 64,
  parameter logic [IW-1:0] NOP_WORD = 32'hD503201F
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IW-1:0]              instruction_in,
  input  logic [AW-1:0]              PC_in,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IW-1:0]              instruction_out,
  output logic [AW-1:0]              PC_out,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [IW-1:0] instr_mem [DEPTH];
  logic [AW-1:0] pc_mem    [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          alive;
  logic          push_ok;
  logic          push;
  logic          pop;

  // Handshake decode and head presentation
  always_comb begin
    in_ready        = alive & (count != CW'(DEPTH));
    push_ok         = in_valid & in_ready & ~flush;
    out_valid       = (count != '0) & ~flush;
    instruction_out = NOP_WORD;
    PC_out          = '0;
    if (out_valid) begin
      instruction_out = instr_mem[rd_ptr];
      PC_out          = pc_mem[rd_ptr];
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    push = push_ok;
    pop  = out_valid & out_ready;
    // Empty queue forwards the incoming fetch; it is only stored if decode stalls
    if (push_ok && (count == '0)) begin
      out_valid       = 1'b1;
      instruction_out = instruction_in;
      PC_out          = PC_in;
      push            = ~out_ready;
      pop             = 1'b0;
    end
`else
    push = push_ok;
    pop  = out_valid & out_ready;
`endif
  end

  // Pointer, occupancy and post-reset ready state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      alive  <= 1'b0;
    end else begin
      alive <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (pop && !push) count <= count - CW'(1);
      end
    end
  end

  // Storage array; contents are meaningless outside the occupied window
  always_ff @(posedge clock) begin
    if (push) begin
      instr_mem[wr_ptr] <= instruction_in;
      pc_mem[wr_ptr]    <= PC_in;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus queues expected head entries,
// a negedge monitor checks every decode handshake against that queue.
module tb_fetch_queue;

  localparam logic [31:0] NOP = 32'hD503201F;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instruction_in = '0;
  logic [63:0] PC_in = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] instruction_out;
  logic [63:0] PC_out;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } entry_t;
  entry_t exp_q[$];

  fetch_queue dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .instruction_in(instruction_in), .PC_in(PC_in),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .instruction_out(instruction_out), .PC_out(PC_out),
    .count(count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drive one fetch whose acceptance is expected; it is queued for the monitor
  task automatic drive(input logic [63:0] pc, input logic [31:0] instr);
    in_valid       = 1'b1;
    PC_in          = pc;
    instruction_in = instr;
    exp_q.push_back({instr, pc});
  endtask

  // Monitor: every handshake must match the oldest expected entry
  always @(negedge clock) begin
    if (out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL mon_unexpected: got pc 0x%0h expected no output", PC_out);
      end else begin
        entry_t e;
        e = exp_q.pop_front();
        chk("mon_pc", PC_out, e.pc);
        chk("mon_instr", 64'(instruction_out), 64'(e.instr));
      end
    end
  end

  initial begin
    logic [31:0] prog [3];
    prog[0] = 32'h8B020020;
    prog[1] = 32'h91000421;
    prog[2] = 32'hD503201F;

    // Reset state
    #2;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_instr", 64'(instruction_out), 64'(NOP));
    chk("rst_pc", PC_out, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    step(); step();
    reset = 1'b1;
    step();
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Basic push of three, then drain in order
    for (int i = 0; i < 3; i++) begin
      drive(64'(i * 4), prog[i]);
      step();
    end
    in_valid = 1'b0;
    chk("t1_count", 64'(count), 64'd3);
    chk("t1_out_valid", 64'(out_valid), 64'd1);
    chk("t1_head_pc", PC_out, 64'h0);
    out_ready = 1'b1;
    step(); step(); step();
    chk("t1_empty_count", 64'(count), 64'd0);
    chk("t1_empty_valid", 64'(out_valid), 64'd0);
    chk("t1_empty_nop", 64'(instruction_out), 64'(NOP));
    out_ready = 1'b0;

    // Fill to full, ignored push, pop frees a slot next cycle
    for (int i = 0; i < 4; i++) begin
      drive(64'h100 + 64'(i * 4), 32'hA000_0000 + 32'(i));
      step();
    end
    chk("t2_full_count", 64'(count), 64'd4);
    chk("t2_full_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1; PC_in = 64'h110; instruction_in = 32'hA000_0004;
    step();
    chk("t2_ignored_count", 64'(count), 64'd4);
    exp_q.push_back({32'hA000_0004, 64'h110});
    out_ready = 1'b1;
    #1;
    chk("t2_pop_cycle_in_ready", 64'(in_ready), 64'd0);
    step();
    out_ready = 1'b0;
    chk("t2_after_pop_in_ready", 64'(in_ready), 64'd1);
    chk("t2_after_pop_count", 64'(count), 64'd3);
    step();
    in_valid = 1'b0;
    chk("t2_refill_count", 64'(count), 64'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("t2_drained", 64'(count), 64'd0);
    out_ready = 1'b0;

    // Streaming at occupancy 2 across pointer wrap
    drive(64'h300, 32'hB000_0000); step();
    drive(64'h304, 32'hB000_0001); step();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(64'h308 + 64'(i * 4), 32'hB000_0002 + 32'(i));
      step();
      chk("t3_stream_count", 64'(count), 64'd2);
    end
    in_valid = 1'b0;
    step(); step();
    chk("t3_drained", 64'(count), 64'd0);
    out_ready = 1'b0;

    // Flush discards queued and incoming entries
    for (int i = 0; i < 3; i++) begin
      drive(64'h500 + 64'(i * 4), 32'hC000_0000 + 32'(i));
      step();
    end
    in_valid = 1'b1; PC_in = 64'h200; instruction_in = 32'hDEAD_0200;
    flush = 1'b1; out_ready = 1'b1;
    #1;
    chk("t4_flush_out_valid", 64'(out_valid), 64'd0);
    exp_q.delete();
    step();
    chk("t4_flush1_count", 64'(count), 64'd0);
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("t4_flush2_count", 64'(count), 64'd0);
    chk("t4_flush2_valid", 64'(out_valid), 64'd0);
    drive(64'h400, 32'hC000_0400);
    step();
    in_valid = 1'b0;
    chk("t4_target_valid", 64'(out_valid), 64'd1);
    chk("t4_target_pc", PC_out, 64'h400);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) begin
      drive(64'h600 + 64'(i * 4), 32'hE000_0000 + 32'(i));
      step();
    end
    in_valid = 1'b0;
    chk("t5_pre_count", 64'(count), 64'd3);
    #2;
    reset = 1'b0;
    #1;
    exp_q.delete();
    chk("t5_rst_count", 64'(count), 64'd0);
    chk("t5_rst_valid", 64'(out_valid), 64'd0);
    chk("t5_rst_in_ready", 64'(in_ready), 64'd0);
    step();
    reset = 1'b1;
    step();
    chk("t5_rel_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    step();
    chk("t5_no_stale", 64'(out_valid), 64'd0);

    // Empty-queue latency (bypass or one cycle)
    drive(64'h80, 32'h1111_0080);
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("t6_byp_valid", 64'(out_valid), 64'd1);
    chk("t6_byp_pc", PC_out, 64'h80);
    step();
    in_valid = 1'b0;
    chk("t6_byp_count", 64'(count), 64'd0);
`else
    chk("t6_nobyp_valid", 64'(out_valid), 64'd0);
    step();
    in_valid = 1'b0;
    chk("t6_nobyp_count", 64'(count), 64'd1);
    chk("t6_nobyp_pc", PC_out, 64'h80);
    step();
    chk("t6_nobyp_drained", 64'(count), 64'd0);
`endif
    out_ready = 1'b0;
    step();

    chk("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
